// File: rtl/ir_pkg.sv
// Shared widths, opcode names and the packed instruction layout for the
// instruction queue register and its storage.
package ir_pkg;

   localparam int IR_WORD_SIZE   = 19;
   localparam int IR_OPCODE_W    = 5;
   localparam int IR_ADDR_W      = IR_WORD_SIZE - IR_OPCODE_W;
   localparam int IR_DEPTH       = 4;
   localparam int IR_NUM_OPCODES = 32;

   typedef enum logic [IR_OPCODE_W-1:0] {
      OP_NOP   = 5'h00,
      OP_LOAD  = 5'h01,
      OP_STORE = 5'h02,
      OP_ADD   = 5'h03,
      OP_SUB   = 5'h04,
      OP_AND   = 5'h05,
      OP_OR    = 5'h06,
      OP_JMP   = 5'h07,
      OP_JZ    = 5'h08,
      OP_HALT  = 5'h1F
   } opcode_t;

   typedef struct packed {
      logic [IR_OPCODE_W-1:0] opcode;
      logic [IR_ADDR_W-1:0]   operand;
   } instr_t;

endpackage

// File: rtl/instruction_queue_register_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
// illegal_op exists only when IR_ILLEGAL_OPCODE_CHECK_EN is defined.
interface instruction_queue_register_if #(
   parameter int WORD_SIZE = ir_pkg::IR_WORD_SIZE,
   parameter int OPCODE_W  = ir_pkg::IR_OPCODE_W,
   parameter int DEPTH     = ir_pkg::IR_DEPTH
);

   logic                          fetch_valid;
   logic                          fetch_ready;
   logic [WORD_SIZE-1:0]          fetch_instr;
   logic                          flush;
   logic                          dec_valid;
   logic                          dec_ready;
   logic [OPCODE_W-1:0]           opcode;
   logic [WORD_SIZE-OPCODE_W-1:0] operand;
   logic [$clog2(DEPTH+1)-1:0]    count;
`ifdef IR_ILLEGAL_OPCODE_CHECK_EN
   logic                          illegal_op;
`endif

   modport master (
      output fetch_valid, fetch_instr, flush, dec_ready,
`ifdef IR_ILLEGAL_OPCODE_CHECK_EN
      input  illegal_op,
`endif
      input  fetch_ready, dec_valid, opcode, operand, count
   );

   modport slave (
      input  fetch_valid, fetch_instr, flush, dec_ready,
`ifdef IR_ILLEGAL_OPCODE_CHECK_EN
      output illegal_op,
`endif
      output fetch_ready, dec_valid, opcode, operand, count
   );

endinterface

// File: rtl/ir_queue_storage.sv
// DEPTH x WORD_SIZE entry array with one write port and an asynchronous read mux.
// Entries are not reset; validity is tracked by the occupancy count in the top.
module ir_queue_storage #(
   parameter int WORD_SIZE = ir_pkg::IR_WORD_SIZE,
   parameter int DEPTH     = ir_pkg::IR_DEPTH
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [WORD_SIZE-1:0]       wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [WORD_SIZE-1:0]       rdata
);

   logic [WORD_SIZE-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_queue_register.sv
// Small FIFO between fetch and decode with registered, pre-split head outputs.
// Optional macro IR_ILLEGAL_OPCODE_CHECK_EN adds the illegal_op flag.
module instruction_queue_register
   import ir_pkg::*;
#(
   parameter int WORD_SIZE   = IR_WORD_SIZE,
   parameter int OPCODE_W    = IR_OPCODE_W,
`ifdef IR_ILLEGAL_OPCODE_CHECK_EN
   parameter int NUM_OPCODES = IR_NUM_OPCODES,
`endif
   parameter int DEPTH       = IR_DEPTH
) (
   input  logic clk,
   input  logic rst_n,
   instruction_queue_register_if.slave bus
);

   localparam int ADDR_W = WORD_SIZE - OPCODE_W;
   localparam int PW     = $clog2(DEPTH);
   localparam int CW     = $clog2(DEPTH + 1);

   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [PW-1:0]        raddr;
   logic [CW-1:0]        count_q;
   logic [CW-1:0]        count_d;
   logic                 fetch_ready_q;
   logic                 dec_valid_q;
   logic                 dec_valid_d;
   logic [WORD_SIZE-1:0] head_q;
   logic [WORD_SIZE-1:0] head_d;
   logic [WORD_SIZE-1:0] stor_rdata;
   logic                 push;
   logic                 pop;

   assign push  = bus.fetch_valid & fetch_ready_q;
   assign pop   = dec_valid_q & bus.dec_ready;
   // On a pop the head register must already hold the entry behind the current one.
   assign raddr = pop ? rd_ptr + PW'(1) : rd_ptr;

   ir_queue_storage #(
      .WORD_SIZE (WORD_SIZE),
      .DEPTH     (DEPTH)
   ) u_storage (
      .clk   (clk),
      .we    (push & ~bus.flush),
      .waddr (wr_ptr),
      .wdata (bus.fetch_instr),
      .raddr (raddr),
      .rdata (stor_rdata)
   );

   always_comb begin
      count_d     = count_q;
      head_d      = head_q;
      dec_valid_d = dec_valid_q;
      if (bus.flush) begin
         count_d     = '0;
         head_d      = '0;
         dec_valid_d = 1'b0;
      end else begin
         count_d = count_q + CW'(push) - CW'(pop);
         // Head only moves when it is consumed or when nothing is being presented.
         if (pop || !dec_valid_q) begin
            if (count_q > CW'(pop)) begin
               head_d      = stor_rdata;
               dec_valid_d = 1'b1;
            end else if (push) begin
               head_d      = bus.fetch_instr;
               dec_valid_d = 1'b1;
            end else begin
               dec_valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count_q       <= '0;
         fetch_ready_q <= 1'b0;
         dec_valid_q   <= 1'b0;
         head_q        <= '0;
      end else begin
         if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
         end
         count_q       <= count_d;
         fetch_ready_q <= (count_d < CW'(DEPTH));
         dec_valid_q   <= dec_valid_d;
         head_q        <= head_d;
      end
   end

`ifdef IR_ILLEGAL_OPCODE_CHECK_EN
   logic illegal_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= (int'(head_d[WORD_SIZE-1 -: OPCODE_W]) >= NUM_OPCODES);
      end
   end

   assign bus.illegal_op = illegal_q & dec_valid_q;
`endif

   assign bus.fetch_ready = fetch_ready_q;
   assign bus.dec_valid   = dec_valid_q;
   assign bus.opcode      = head_q[WORD_SIZE-1 -: OPCODE_W];
   assign bus.operand     = head_q[ADDR_W-1:0];
   assign bus.count       = count_q;

endmodule

// File: tb/tb_instruction_queue_register.sv
// Self-checking bench for instruction_queue_register against a queue-level model.
// Define IR_ILLEGAL_OPCODE_CHECK_EN to also exercise the illegal_op flag.
module tb_instruction_queue_register;
   import ir_pkg::*;

   localparam int WS    = 19;
   localparam int OW    = 5;
   localparam int DEPTH = 4;
`ifdef IR_ILLEGAL_OPCODE_CHECK_EN
   localparam int NUM_OPS = 24;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [WS-1:0] m_q[$];
   bit            m_ready;
   logic [WS-1:0] exp_del[$];
   logic [WS-1:0] obs_del[$];

   always #5 clk = ~clk;

   instruction_queue_register_if #(.WORD_SIZE(WS), .OPCODE_W(OW), .DEPTH(DEPTH)) bus ();

   instruction_queue_register #(
      .WORD_SIZE   (WS),
      .OPCODE_W    (OW),
`ifdef IR_ILLEGAL_OPCODE_CHECK_EN
      .NUM_OPCODES (NUM_OPS),
`endif
      .DEPTH       (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic set_in(input logic fv, input logic [WS-1:0] w, input logic fl, input logic dr);
      bus.fetch_valid = fv;
      bus.fetch_instr = w;
      bus.flush       = fl;
      bus.dec_ready   = dr;
   endtask

   // Advance one clock: record the DUT's delivered word, apply the queue model, settle.
   task automatic cycle();
      logic [WS-1:0] w;
      bit pop;
      bit push;
      if (bus.dec_valid === 1'b1 && bus.dec_ready === 1'b1)
         obs_del.push_back({bus.opcode, bus.operand});
      @(posedge clk);
      if (!rst_n) begin
         m_q.delete();
         m_ready = 1'b0;
      end else begin
         pop  = (m_q.size() > 0) && bus.dec_ready;
         push = bus.fetch_valid && m_ready;
         if (pop) begin
            w = m_q.pop_front();
            exp_del.push_back(w);
         end
         if (bus.flush) m_q.delete();
         else if (push) m_q.push_back(bus.fetch_instr);
         m_ready = (m_q.size() < DEPTH);
      end
      #1;
   endtask

   task automatic test_reset();
      set_in(1'b0, '0, 1'b0, 1'b0);
      rst_n = 1'b0;
      m_q.delete();
      m_ready = 1'b0;
      #12;
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
      checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %b want 0", bus.dec_valid); end
      checks++; if (bus.fetch_ready !== 1'b0) begin errors++; $display("FAIL reset_fetch_ready: got %b want 0", bus.fetch_ready); end
      checks++; if (bus.opcode !== 5'd0 || bus.operand !== 14'd0) begin errors++; $display("FAIL reset_head: got %h/%h want 0/0", bus.opcode, bus.operand); end
      rst_n = 1'b1;
      cycle();
      checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b want 1", bus.fetch_ready); end
      checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b want 0", bus.dec_valid); end
   endtask

   task automatic test_fill_drain();
      logic [WS-1:0] w;
      exp_del.delete(); obs_del.delete();
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 19'h1ABCD + WS'(i), 1'b0, 1'b0);
         cycle();
      end
      set_in(1'b0, '0, 1'b0, 1'b0);
      checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", bus.count); end
      checks++; if (bus.fetch_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b want 0", bus.fetch_ready); end
      w = 19'h1ABCD;
      checks++; if (bus.opcode !== w[18:14] || bus.operand !== w[13:0]) begin
         errors++; $display("FAIL fill_head_split: got %h/%h want %h/%h", bus.opcode, bus.operand, w[18:14], w[13:0]); end
      for (int i = 0; i < 4; i++) begin
         w = 19'h1ABCD + WS'(i);
         checks++; if (bus.dec_valid !== 1'b1 || {bus.opcode, bus.operand} !== w) begin
            errors++; $display("FAIL drain_word%0d: got v=%b %h want v=1 %h", i, bus.dec_valid, {bus.opcode, bus.operand}, w); end
         set_in(1'b0, '0, 1'b0, 1'b1);
         cycle();
         if (i == 0) begin
            checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL drain_ready_back: got %b want 1", bus.fetch_ready); end
         end
      end
      checks++; if (bus.count !== 3'd0 || bus.dec_valid !== 1'b0) begin
         errors++; $display("FAIL drain_empty: got count=%0d v=%b want 0/0", bus.count, bus.dec_valid); end
      checks++; if (obs_del.size() != 4) begin errors++; $display("FAIL drain_delivered: got %0d words want 4", obs_del.size()); end
   endtask

   task automatic test_streaming();
      logic [WS-1:0] w;
      exp_del.delete(); obs_del.delete();
      for (int c = 0; c < 20; c++) begin
         w = WS'($urandom);
         set_in(1'b1, w, 1'b0, 1'b1);
         cycle();
         checks++; if (bus.count !== 3'd1 || bus.dec_valid !== 1'b1) begin
            errors++; $display("FAIL stream_occ c%0d: got count=%0d v=%b want 1/1", c, bus.count, bus.dec_valid); end
         checks++; if ({bus.opcode, bus.operand} !== w) begin
            errors++; $display("FAIL stream_head c%0d: got %h want %h", c, {bus.opcode, bus.operand}, w); end
      end
      checks++; if (obs_del.size() != 19) begin errors++; $display("FAIL stream_rate: got %0d words want 19", obs_del.size()); end
      set_in(1'b0, '0, 1'b0, 1'b1);
      cycle();
      checks++; if (obs_del.size() != exp_del.size()) begin
         errors++; $display("FAIL stream_total: got %0d words want %0d", obs_del.size(), exp_del.size()); end
      else for (int i = 0; i < obs_del.size(); i++) begin
         checks++; if (obs_del[i] !== exp_del[i]) begin errors++; $display("FAIL stream_order%0d: got %h want %h", i, obs_del[i], exp_del[i]); end
      end
   endtask

   task automatic test_full_pop();
      logic [WS-1:0] wp;
      exp_del.delete(); obs_del.delete();
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, WS'($urandom), 1'b0, 1'b0);
         cycle();
      end
      checks++; if (bus.count !== 3'd4 || bus.fetch_ready !== 1'b0) begin
         errors++; $display("FAIL full_state: got count=%0d rdy=%b want 4/0", bus.count, bus.fetch_ready); end
      wp = 19'h5A5A5;
      set_in(1'b1, wp, 1'b0, 1'b1);
      cycle();
      checks++; if (bus.count !== 3'd3 || bus.fetch_ready !== 1'b1) begin
         errors++; $display("FAIL full_pop_only: got count=%0d rdy=%b want 3/1", bus.count, bus.fetch_ready); end
      set_in(1'b1, wp, 1'b0, 1'b0);
      cycle();
      checks++; if (bus.count !== 3'd4 || bus.fetch_ready !== 1'b0) begin
         errors++; $display("FAIL full_pending_accept: got count=%0d rdy=%b want 4/0", bus.count, bus.fetch_ready); end
      set_in(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cycle();
      checks++; if (obs_del.size() != 5 || obs_del[obs_del.size()-1] !== wp) begin
         errors++; $display("FAIL full_pending_delivered: got %0d words last=%h want 5 last=%h", obs_del.size(),
                             (obs_del.size() > 0) ? obs_del[obs_del.size()-1] : '0, wp); end
   endtask

   task automatic test_flush();
      exp_del.delete(); obs_del.delete();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 19'h21110 + WS'(i), 1'b0, 1'b0);
         cycle();
      end
      checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d want 3", bus.count); end
      set_in(1'b1, 19'h00001, 1'b1, 1'b1);
      cycle();
      checks++; if (bus.count !== 3'd0 || bus.dec_valid !== 1'b0) begin
         errors++; $display("FAIL flush_clear: got count=%0d v=%b want 0/0", bus.count, bus.dec_valid); end
      checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", bus.fetch_ready); end
      set_in(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle();
      checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_empty: got %b want 0", bus.dec_valid); end
      foreach (obs_del[i]) begin
         checks++; if (obs_del[i] === 19'h00001) begin errors++; $display("FAIL flush_discard: got %h delivered want never", obs_del[i]); end
      end
   endtask

   task automatic test_async_reset();
      logic [WS-1:0] w;
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, WS'($urandom), 1'b0, 1'b0);
         cycle();
      end
      checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL areset_pre_count: got %0d want 2", bus.count); end
      #2;
      rst_n = 1'b0;
      m_q.delete(); m_ready = 1'b0;
      exp_del.delete(); obs_del.delete();
      #1;
      checks++; if (bus.count !== 3'd0 || bus.dec_valid !== 1'b0 || bus.fetch_ready !== 1'b0) begin
         errors++; $display("FAIL areset_immediate: got count=%0d v=%b rdy=%b want 0/0/0", bus.count, bus.dec_valid, bus.fetch_ready); end
      checks++; if (bus.opcode !== 5'd0 || bus.operand !== 14'd0) begin
         errors++; $display("FAIL areset_head: got %h/%h want 0/0", bus.opcode, bus.operand); end
      #2;
      rst_n = 1'b1;
      w = 19'h3C0DE;
      set_in(1'b1, w, 1'b0, 1'b0);
      cycle();
      cycle();
      set_in(1'b0, '0, 1'b0, 1'b0);
      checks++; if (bus.count !== 3'd1 || bus.dec_valid !== 1'b1 || {bus.opcode, bus.operand} !== w) begin
         errors++; $display("FAIL areset_sole_entry: got count=%0d v=%b %h want 1/1 %h", bus.count, bus.dec_valid, {bus.opcode, bus.operand}, w); end
      set_in(1'b0, '0, 1'b0, 1'b1);
      cycle();
      checks++; if (obs_del.size() != 1 || obs_del[0] !== w || bus.count !== 3'd0) begin
         errors++; $display("FAIL areset_deliver: got %0d words count=%0d want 1 word %h count=0", obs_del.size(), bus.count, w); end
   endtask

   task automatic test_random();
      exp_del.delete(); obs_del.delete();
      for (int c = 0; c < 300; c++) begin
         set_in(1'($urandom_range(0, 1)), WS'($urandom), ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
         cycle();
         checks++; if (bus.count !== 3'(m_q.size()) || bus.dec_valid !== (m_q.size() > 0) || bus.fetch_ready !== m_ready) begin
            errors++; $display("FAIL rand_state c%0d: got count=%0d v=%b rdy=%b want %0d/%b/%b", c, bus.count, bus.dec_valid,
                               bus.fetch_ready, m_q.size(), (m_q.size() > 0), m_ready); end
         if (m_q.size() > 0) begin
            checks++; if ({bus.opcode, bus.operand} !== m_q[0]) begin
               errors++; $display("FAIL rand_head c%0d: got %h want %h", c, {bus.opcode, bus.operand}, m_q[0]); end
`ifdef IR_ILLEGAL_OPCODE_CHECK_EN
            checks++; if (bus.illegal_op !== (int'(m_q[0][18:14]) >= NUM_OPS)) begin
               errors++; $display("FAIL rand_illegal c%0d: got %b want %b", c, bus.illegal_op, (int'(m_q[0][18:14]) >= NUM_OPS)); end
`endif
         end
      end
      checks++; if (obs_del.size() != exp_del.size()) begin
         errors++; $display("FAIL rand_total: got %0d words want %0d", obs_del.size(), exp_del.size()); end
      else for (int i = 0; i < obs_del.size(); i++) begin
         checks++; if (obs_del[i] !== exp_del[i]) begin errors++; $display("FAIL rand_order%0d: got %h want %h", i, obs_del[i], exp_del[i]); end
      end
   endtask

`ifdef IR_ILLEGAL_OPCODE_CHECK_EN
   task automatic test_illegal();
      set_in(1'b0, '0, 1'b1, 1'b0);
      cycle();
      checks++; if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL illegal_after_flush: got %b want 0", bus.illegal_op); end
      set_in(1'b1, {5'h18, 14'h0123}, 1'b0, 1'b0);
      cycle();
      checks++; if (bus.illegal_op !== 1'b1 || bus.dec_valid !== 1'b1) begin
         errors++; $display("FAIL illegal_0x18: got ill=%b v=%b want 1/1", bus.illegal_op, bus.dec_valid); end
      set_in(1'b1, {5'h17, 14'h0456}, 1'b0, 1'b1);
      cycle();
      checks++; if (bus.illegal_op !== 1'b0 || bus.opcode !== 5'h17) begin
         errors++; $display("FAIL illegal_0x17: got ill=%b op=%h want 0/17", bus.illegal_op, bus.opcode); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_fill_drain();
      test_streaming();
      test_full_pop();
      test_flush();
      test_async_reset();
      test_random();
`ifdef IR_ILLEGAL_OPCODE_CHECK_EN
      test_illegal();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
